instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle R-type datapath top level. Holds the program counter and a word-addressed instruction memory, and presents one 32-bit instruction per cycle on a valid/ready handshake. The datapath consumes `instr` as its `instruction` input. The block supports branch/jump redirection with flush, back-pressure stalls, program loading through a write port, a sticky misalignment fault and a saturating accepted-instruction counter.

---
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, word-addressed instruction memory, registered valid/ready output.
// Latency: 1 cycle from fetch issue to instr_valid; redirect costs one bubble.
// Backpressure: instr_ready low holds instr/instr_pc/instr_valid and the PC.
module instr_fetch #(
    parameter int          MEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    localparam int         AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          fault,
    output logic [15:0]   fetch_count
);

    typedef struct packed {
        logic [31:0] dat;
        logic [31:0] pc;
    } fetch_t;

    logic [31:0] mem [MEM_DEPTH];

    logic [31:0] pc_q, pc_nxt;
    fetch_t      out_q, out_nxt;
    logic        out_vld_q, out_vld_nxt;
    logic        fault_q, fault_nxt;
    logic [15:0] cnt_q;
    logic        accept, slot_free;
    logic [31:0] rd_dat;

    assign accept    = out_vld_q & instr_ready;
    assign slot_free = ~out_vld_q | instr_ready;
    // Upper PC bits are dropped, so fetch addresses wrap around the array.
    assign rd_dat    = mem[pc_q[AW+1:2]];

    always_comb begin
        pc_nxt      = pc_q;
        out_nxt     = out_q;
        out_vld_nxt = out_vld_q;
        fault_nxt   = fault_q;
        if (fault_q) begin
            out_vld_nxt = 1'b0;
        end else if (redirect_valid) begin
            // Flush even if the held instruction is accepted this cycle.
            out_vld_nxt = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_nxt = 1'b1;
            end else begin
                pc_nxt = redirect_pc;
            end
        end else if (run && slot_free) begin
            out_nxt.dat = rd_dat;
            out_nxt.pc  = pc_q;
            out_vld_nxt = 1'b1;
            pc_nxt      = pc_q + 32'd4;
        end else if (accept) begin
            out_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_nxt;
            out_q     <= out_nxt;
            out_vld_q <= out_vld_nxt;
            fault_q   <= fault_nxt;
            if (accept && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // Array is not reset; nonblocking write gives read-before-write on a same-index fetch.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign instr       = out_q.dat;
    assign instr_pc    = out_q.pc;
    assign instr_valid = out_vld_q;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven cycle vectors, accepted-instruction
// scoreboard, and hand sequences for reset, wrap/write collision, saturation and async reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fault;
    logic [15:0] fetch_count;

    instr_fetch #(.MEM_DEPTH(64), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          run;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          acc;
        logic [31:0] acc_pc;
        bit          e_vld;
        logic [31:0] e_pc;
        bit          e_flt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] sb_q[$];
    bit          sb_en = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    function automatic vec_t mk(bit r, bit rd, bit rv, logic [31:0] rpc, bit acc,
                                logic [31:0] apc, bit ev, logic [31:0] epc, bit ef,
                                logic [15:0] ec);
        vec_t v;
        v.run = r; v.rdy = rd; v.rv = rv; v.rpc = rpc; v.acc = acc; v.acc_pc = apc;
        v.e_vld = ev; v.e_pc = epc; v.e_flt = ef; v.e_cnt = ec;
        return v;
    endfunction

    // Memory image loaded at start: word i = 0x20 + i.
    function automatic logic [31:0] word_at(logic [31:0] pc);
        return 32'h0000_0020 + ((pc >> 2) & 32'd63);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard sampled at the falling edge, where an accept is about to happen.
    task automatic step();
        logic [63:0] e;
        @(negedge clk);
        if (sb_en && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_accept_pc", instr_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_accept_pc", instr_pc, e[63:32]);
                chk("sb_accept_instr", instr, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0; instr_ready = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) begin
            prog_we = 1'b1; prog_addr = 6'(i); prog_data = 32'h0000_0020 + 32'(i);
            step();
        end
        prog_we = 1'b0;
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_count", {16'b0, fetch_count}, 32'h0);
        reset = 1'b0;

        // Straight line, drain, back-pressure, redirect flush, misaligned fault.
        tbl.push_back(mk(1,1,0,0,     0,0,  1,0, 0,0));
        tbl.push_back(mk(1,1,0,0,     1,0,  1,4, 0,1));
        tbl.push_back(mk(1,1,0,0,     1,4,  1,8, 0,2));
        tbl.push_back(mk(1,1,0,0,     1,8,  1,12,0,3));
        tbl.push_back(mk(0,1,0,0,     1,12, 0,0, 0,4));
        tbl.push_back(mk(1,1,1,32'h4, 0,0,  0,0, 0,4));
        tbl.push_back(mk(1,0,0,0,     0,0,  1,4, 0,4));
        tbl.push_back(mk(1,0,0,0,     0,0,  1,4, 0,4));
        tbl.push_back(mk(1,0,0,0,     0,0,  1,4, 0,4));
        tbl.push_back(mk(1,0,0,0,     0,0,  1,4, 0,4));
        tbl.push_back(mk(1,1,0,0,     1,4,  1,8, 0,5));
        tbl.push_back(mk(1,1,1,32'h10,1,8,  0,0, 0,6));
        tbl.push_back(mk(1,1,0,0,     0,0,  1,16,0,6));
        tbl.push_back(mk(1,1,0,0,     1,16, 1,20,0,7));
        tbl.push_back(mk(1,1,1,32'h6, 1,20, 0,0, 1,8));
        tbl.push_back(mk(1,1,1,32'h20,0,0,  0,0, 1,8));
        tbl.push_back(mk(1,1,0,0,     0,0,  0,0, 1,8));

        sb_en = 1'b1;
        foreach (tbl[k]) begin
            run = tbl[k].run; instr_ready = tbl[k].rdy;
            redirect_valid = tbl[k].rv; redirect_pc = tbl[k].rpc;
            if (tbl[k].acc) sb_q.push_back({tbl[k].acc_pc, word_at(tbl[k].acc_pc)});
            step();
            chk($sformatf("row%0d_valid", k), {31'b0, instr_valid}, {31'b0, tbl[k].e_vld});
            chk($sformatf("row%0d_fault", k), {31'b0, fault}, {31'b0, tbl[k].e_flt});
            chk($sformatf("row%0d_count", k), {16'b0, fetch_count}, {16'b0, tbl[k].e_cnt});
            if (tbl[k].e_vld) begin
                chk($sformatf("row%0d_pc", k), instr_pc, tbl[k].e_pc);
                chk($sformatf("row%0d_instr", k), instr, word_at(tbl[k].e_pc));
            end
        end
        sb_en = 1'b0;
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);

        // Reset clears the sticky fault; fetch restarts at RESET_PC.
        redirect_valid = 1'b0; run = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("fault_cleared", {31'b0, fault}, 32'h0);
        run = 1'b1; instr_ready = 1'b1;
        step();
        chk("restart_valid", {31'b0, instr_valid}, 32'h1);
        chk("restart_pc", instr_pc, 32'h0);
        chk("restart_instr", instr, 32'h0000_0020);

        // Wrap-around and write collision at index 0.
        redirect_valid = 1'b1; redirect_pc = 32'hFC;
        step();
        chk("wrap_redirect_valid", {31'b0, instr_valid}, 32'h0);
        redirect_valid = 1'b0;
        step();
        chk("wrap_pc_252", instr_pc, 32'd252);
        chk("wrap_instr_252", instr, 32'h0000_005F);
        prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'hDEAD_BEEF;
        step();
        prog_we = 1'b0;
        chk("wrap_pc_256", instr_pc, 32'd256);
        chk("collision_old_word", instr, 32'h0000_0020);
        step();
        chk("wrap_pc_260", instr_pc, 32'd260);
        chk("wrap_instr_260", instr, 32'h0000_0021);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        step();
        chk("new_word_pc", instr_pc, 32'h0);
        chk("new_word_instr", instr, 32'hDEAD_BEEF);

        // Saturation after 65537 accepts, then asynchronous reset between edges.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("sat_start_count", {16'b0, fetch_count}, 32'h0);
        for (int i = 0; i < 65537; i++) @(posedge clk);
        #1;
        chk("sat_count", {16'b0, fetch_count}, 32'h0000_FFFF);
        chk("sat_valid", {31'b0, instr_valid}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_instr", instr, 32'h0);
        chk("arst_instr_pc", instr_pc, 32'h0);
        chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_fault", {31'b0, fault}, 32'h0);
        chk("arst_count", {16'b0, fetch_count}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("post_arst_pc", instr_pc, 32'h0);
        chk("post_arst_instr", instr, 32'hDEAD_BEEF);
        chk("post_arst_count", {16'b0, fetch_count}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
